// File: rtl/pad_ctl_pkg.sv
// Shared definitions for the bidirectional pad bus controller.
//   state_e   : controller FSM states
//   DIR_IN    : external device drives the pads
//   DIR_OUT   : controller drives the pads
//   cnt_width : width of the shared phase down-counter
package pad_ctl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTa,
        StWrSetup,
        StWrStb,
        StWrHold,
        StRdStb,
        StRdDone
    } state_e;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // Wide enough to hold (largest phase length - 1) with one spare bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return int'($clog2(m)) + 1;
    endfunction

endpackage

// File: rtl/pad_bidir_ctrl_if.sv
// Core-side request/response bundle of the pad bus controller.
//   tx_valid/tx_ready/tx_data : write request handshake
//   rd_req                    : read request level
//   rd_valid/rd_data          : read result pulse and data
//   busy                      : controller not idle
//   rd_perr                   : read parity error (only with PADCTL_PARITY_EN)
// Modports: master = core logic, slave = pad_bidir_ctrl.
interface pad_bidir_ctrl_if #(
    parameter int unsigned W = 8
);

    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] tx_data;
    logic         rd_req;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         busy;
`ifdef PADCTL_PARITY_EN
    logic         rd_perr;
`endif

    modport master (
        output tx_valid, tx_data, rd_req,
`ifdef PADCTL_PARITY_EN
        input  rd_perr,
`endif
        input  tx_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  tx_valid, tx_data, rd_req,
`ifdef PADCTL_PARITY_EN
        output rd_perr,
`endif
        output tx_ready, rd_valid, rd_data, busy
    );

endinterface

// File: rtl/pad_sync.sv
// Two-flop synchronizer for asynchronous pad inputs.
//   clk, rst_n : clock, async active-low reset (flops clear to 0)
//   d          : asynchronous input
//   q          : synchronized output, two cycles of latency
module pad_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pad_bidir_ctrl.sv
// Core-side controller for a half-duplex bidirectional parallel pad bus.
// Turns core writes/reads into timed pad cycles: turnaround dead time,
// setup/strobe/hold sequencing and synchronized read capture.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   core (slave)     : tx_valid/tx_ready/tx_data, rd_req, rd_valid/rd_data, busy
//   pad_dout, pad_oe : to pad DataOut / EN (1 = drive)
//   pad_din          : from pad DataIn, asynchronous
//   pad_stb          : bus strobe, active high
//   pad_dir          : 1 = controller drives, 0 = external device drives
// Optional build macro PADCTL_PARITY_EN adds pad_par_out, pad_par_oe,
// pad_par_in and core.rd_perr (even parity over the data bus).
module pad_bidir_ctrl
    import pad_ctl_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned TA_CYC    = 2,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned STB_CYC   = 3,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pad_bidir_ctrl_if.slave  core,
    output logic [W-1:0]     pad_dout,
    output logic             pad_oe,
    input  logic [W-1:0]     pad_din,
    output logic             pad_stb,
    output logic             pad_dir
`ifdef PADCTL_PARITY_EN
    ,
    output logic             pad_par_out,
    output logic             pad_par_oe,
    input  logic             pad_par_in
`endif
);

    localparam int unsigned CW = cnt_width(TA_CYC, SETUP_CYC, STB_CYC, HOLD_CYC);

    // Counter load values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CW-1:0] TA_LD    = CW'(TA_CYC - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STB_LD   = CW'(STB_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

`ifdef PADCTL_PARITY_EN
    localparam int unsigned SW = W + 1;
`else
    localparam int unsigned SW = W;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          pad_oe_q, pad_oe_d;
    logic          pad_stb_q, pad_stb_d;
    logic [W-1:0]  pad_dout_q, pad_dout_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          accept_wr;
    logic          capture;

    logic [SW-1:0] sync_in;
    logic [SW-1:0] sync_out;

`ifdef PADCTL_PARITY_EN
    assign sync_in = {pad_par_in, pad_din};
`else
    assign sync_in = pad_din;
`endif

    pad_sync #(
        .W (SW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_in),
        .q     (sync_out)
    );

    // Next-state and counter. TA is shared by both turnaround directions;
    // dir_q (already updated at accept) tells which phase follows it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        accept_wr = 1'b0;
        capture   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (core.tx_valid) begin
                    accept_wr = 1'b1;
                    dir_d     = DIR_OUT;
                    if (dir_q == DIR_OUT) begin
                        state_d = StWrSetup;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = StTa;
                        cnt_d   = TA_LD;
                    end
                end else if (core.rd_req) begin
                    dir_d = DIR_IN;
                    if (dir_q == DIR_OUT) begin
                        state_d = StTa;
                        cnt_d   = TA_LD;
                    end else begin
                        state_d = StRdStb;
                        cnt_d   = STB_LD;
                    end
                end
            end
            StTa: begin
                if (cnt_q == '0) begin
                    if (dir_q == DIR_OUT) begin
                        state_d = StWrSetup;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = StRdStb;
                        cnt_d   = STB_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrSetup: begin
                if (cnt_q == '0) begin
                    state_d = StWrStb;
                    cnt_d   = STB_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrStb: begin
                if (cnt_q == '0) begin
                    state_d = StWrHold;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHold: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRdStb: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = StRdDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRdDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered pad outputs are decoded from the next state so every pad
    // pin changes exactly on the clock edge that enters a phase.
    always_comb begin
        pad_oe_d   = 1'b0;
        pad_stb_d  = 1'b0;
        pad_dout_d = accept_wr ? core.tx_data : pad_dout_q;
        rd_data_d  = capture ? sync_out[W-1:0] : rd_data_q;
        rd_valid_d = capture;

        unique case (state_d)
            StWrSetup, StWrHold: pad_oe_d = 1'b1;
            StWrStb: begin
                pad_oe_d  = 1'b1;
                pad_stb_d = 1'b1;
            end
            StRdStb:  pad_stb_d = 1'b1;
            // Keep driving after a write so back-to-back writes skip TA.
            StIdle:   pad_oe_d = pad_oe_q;
            default:  pad_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dir_q      <= DIR_IN;
            pad_oe_q   <= 1'b0;
            pad_stb_q  <= 1'b0;
            pad_dout_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            pad_oe_q   <= pad_oe_d;
            pad_stb_q  <= pad_stb_d;
            pad_dout_q <= pad_dout_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef PADCTL_PARITY_EN
    logic par_out_q, par_out_d;
    logic par_oe_q;
    logic rd_perr_q, rd_perr_d;

    always_comb begin
        par_out_d = accept_wr ? ^core.tx_data : par_out_q;
        rd_perr_d = capture & ((^sync_out[W-1:0]) ^ sync_out[W]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_out_q <= 1'b0;
            par_oe_q  <= 1'b0;
            rd_perr_q <= 1'b0;
        end else begin
            par_out_q <= par_out_d;
            par_oe_q  <= pad_oe_d;
            rd_perr_q <= rd_perr_d;
        end
    end

    assign pad_par_out  = par_out_q;
    assign pad_par_oe   = par_oe_q;
    assign core.rd_perr = rd_perr_q;
`endif

    assign pad_dout      = pad_dout_q;
    assign pad_oe        = pad_oe_q;
    assign pad_stb       = pad_stb_q;
    assign pad_dir       = dir_q;
    assign core.tx_ready = (state_q == StIdle);
    assign core.busy     = (state_q != StIdle);
    assign core.rd_valid = rd_valid_q;
    assign core.rd_data  = rd_data_q;

endmodule
